// File: rtl/vend_bcd_display_ctrl_pkg.sv
// vend_pkg: shared types and constants for the vending BCD display controller.
//   state_t        conversion FSM states
//   BIN_W          binary input width
//   NUM_SHIFTS     double-dabble shift count (one per binary bit)
//   BCD_BLANK      digit code driven for a blanked position
//   SCAN_DIV_DEF   default scan prescaler divide
//   bcd_adj()      double-dabble add-3 correction for one BCD digit
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int          BIN_W        = 7;
   localparam int          NUM_SHIFTS   = 7;
   localparam logic [3:0]  BCD_BLANK    = 4'hF;
   localparam int          SCAN_DIV_DEF = 50000;

   function automatic logic [3:0] bcd_adj(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/vend_bcd_display_ctrl_digit_scan.sv
// digit_scan: multiplexes three latched BCD digits onto a common-anode display.
//   clk, reset         system clock, synchronous active-high reset
//   hundreds/tens/ones latched BCD result to display
//   an[2:0]            active-low digit enables (0 = ones, 1 = tens, 2 = hundreds)
//   digit[3:0]         BCD code of the enabled digit, BCD_BLANK when blanked
// Each digit stays enabled for SCAN_DIV clocks; BLANK_LZ suppresses leading zeros.
module digit_scan
   import vend_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEF,
   parameter int BLANK_LZ = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [2:0] an,
   output logic [3:0] digit
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic          wrap;
   logic          blank_h, blank_t;

   always_comb begin
      wrap    = (presc_q == PW'(SCAN_DIV - 1));
      presc_d = wrap ? '0 : (presc_q + PW'(1));
      idx_d   = idx_q;
      if (wrap) begin
         idx_d = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   // Ones is never blanked; tens only blanks when hundreds is also zero.
   always_comb begin
      blank_h = (BLANK_LZ != 0) && (hundreds == 4'd0);
      blank_t = blank_h && (tens == 4'd0);
      an      = 3'b111;
      digit   = BCD_BLANK;
      case (idx_q)
         2'd0: begin
            an    = 3'b110;
            digit = ones;
         end
         2'd1: begin
            an    = 3'b101;
            digit = blank_t ? BCD_BLANK : tens;
         end
         2'd2: begin
            an    = 3'b011;
            digit = blank_h ? BCD_BLANK : hundreds;
         end
         default: begin
            an    = 3'b111;
            digit = BCD_BLANK;
         end
      endcase
   end

endmodule

// File: rtl/vend_bcd_display_ctrl.sv
// vend_bcd_display_ctrl: round-robin arbiter plus shared double-dabble
// binary-to-BCD converter for credit and change values, feeding a
// multiplexed 3-digit seven-segment display.
//   clk, reset                 system clock, synchronous active-high reset
//   req_credit/val_credit      credit source request and 7-bit value
//   req_change/val_change      change source request and 7-bit value
//   grant[1:0]                 one-hot grant (0 credit, 1 change), IDLE only
//   busy, done                 conversion in progress / one-cycle completion
//   src                        source of the latched result
//   hundreds/tens/ones         latched BCD result
//   an[2:0], digit[3:0]        display scan outputs
//
// state | meaning
// IDLE  | arbitrate; on grant capture value, clear working digits
// SHIFT | one add-3/shift step per clock, 7 steps, last one latches result
// DONE  | done pulse for one clock, requests ignored
module vend_bcd_display_ctrl
   import vend_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEF,
   parameter int BLANK_LZ = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_credit,
   input  logic [BIN_W-1:0] val_credit,
   input  logic             req_change,
   input  logic [BIN_W-1:0] val_change,
   output logic [1:0]       grant,
   output logic             busy,
   output logic             done,
   output logic             src,
   output logic [3:0]       hundreds,
   output logic [3:0]       tens,
   output logic [3:0]       ones,
   output logic [2:0]       an,
   output logic [3:0]       digit
);

   state_t           state_q, state_d;
   logic [BIN_W-1:0] shreg_q, shreg_d;
   logic [3:0]       wh_q, wh_d, wt_q, wt_d, wo_q, wo_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             src_nxt_q, src_nxt_d;
   logic             src_q, src_d;
   logic             ptr_q, ptr_d;
   logic [3:0]       res_h_q, res_h_d, res_t_q, res_t_d, res_o_q, res_o_d;
   logic [3:0]       adj_h, adj_t, adj_o;

   // ptr_q holds the last granted source; a tie goes to the other one.
   always_comb begin
      grant = 2'b00;
      if (state_q == IDLE) begin
         if (req_credit && req_change) begin
            grant = ptr_q ? 2'b01 : 2'b10;
         end else begin
            grant = {req_change, req_credit};
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      wh_d      = wh_q;
      wt_d      = wt_q;
      wo_d      = wo_q;
      cnt_d     = cnt_q;
      src_nxt_d = src_nxt_q;
      src_d     = src_q;
      ptr_d     = ptr_q;
      res_h_d   = res_h_q;
      res_t_d   = res_t_q;
      res_o_d   = res_o_q;
      adj_h     = bcd_adj(wh_q);
      adj_t     = bcd_adj(wt_q);
      adj_o     = bcd_adj(wo_q);
      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               shreg_d   = grant[0] ? val_credit : val_change;
               wh_d      = 4'd0;
               wt_d      = 4'd0;
               wo_d      = 4'd0;
               cnt_d     = 3'd0;
               src_nxt_d = grant[1];
               ptr_d     = grant[1];
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Adjust then shift {h,t,o,shreg} left; the binary MSB enters ones.
            wh_d    = {adj_h[2:0], adj_t[3]};
            wt_d    = {adj_t[2:0], adj_o[3]};
            wo_d    = {adj_o[2:0], shreg_q[BIN_W-1]};
            shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'(NUM_SHIFTS - 1)) begin
               res_h_d = {adj_h[2:0], adj_t[3]};
               res_t_d = {adj_t[2:0], adj_o[3]};
               res_o_d = {adj_o[2:0], shreg_q[BIN_W-1]};
               src_d   = src_nxt_q;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         wh_q      <= 4'd0;
         wt_q      <= 4'd0;
         wo_q      <= 4'd0;
         cnt_q     <= 3'd0;
         src_nxt_q <= 1'b0;
         src_q     <= 1'b0;
         ptr_q     <= 1'b1;
         res_h_q   <= 4'd0;
         res_t_q   <= 4'd0;
         res_o_q   <= 4'd0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         wh_q      <= wh_d;
         wt_q      <= wt_d;
         wo_q      <= wo_d;
         cnt_q     <= cnt_d;
         src_nxt_q <= src_nxt_d;
         src_q     <= src_d;
         ptr_q     <= ptr_d;
         res_h_q   <= res_h_d;
         res_t_q   <= res_t_d;
         res_o_q   <= res_o_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign src      = src_q;
   assign hundreds = res_h_q;
   assign tens     = res_t_q;
   assign ones     = res_o_q;

   digit_scan #(
      .SCAN_DIV (SCAN_DIV),
      .BLANK_LZ (BLANK_LZ)
   ) u_scan (
      .clk      (clk),
      .reset    (reset),
      .hundreds (res_h_q),
      .tens     (res_t_q),
      .ones     (res_o_q),
      .an       (an),
      .digit    (digit)
   );

endmodule
